sddr_init_sequencer: RTL and testbench

- Generates the DDR3 power-up/initialisation command sequence and periodic auto-refresh.
- Drives the command inputs of the Xilinx PHY (ctl_cke/ras_n/cas_n/we_n/odt plus bank/address) and the DDR3 reset line.
- Sits directly upstream of the PHY. The future read/write scheduler shares the command bus through a request/grant handshake.
- Runs entirely in the DDR clock domain.

---
 rtl/sddr_pkg.sv | 71 +++++++
 rtl/sddr_timer.sv | 33 +++
 rtl/sddr_init_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_sddr_init_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sddr_pkg.sv
// ---------------------------------------------------------------------------
// sddr_pkg
// Shared definitions for the DDR3 init/refresh sequencer:
//   cmd_t     - DDR3 command encodings as {ras_n, cas_n, we_n}
//   state_t   - sequencer states
//   DEF_*     - default timing constants (DDR clock cycles) and mode values
//   max_timing- helper that sizes the shared wait counter
// ---------------------------------------------------------------------------
package sddr_pkg;

  typedef enum logic [2:0] {
    CMD_MRS  = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_ZQCL = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_t;

  // Each MRSx / ZQCL / REF_* state is the wait that follows the command of
  // the same name, so the state tells which command was issued last.
  typedef enum logic [3:0] {
    ST_RST_HOLD,
    ST_CKE_WAIT,
    ST_XPR_WAIT,
    ST_MRS2,
    ST_MRS3,
    ST_MRS1,
    ST_MRS0,
    ST_ZQCL,
    ST_IDLE,
    ST_REF_PRE,
    ST_REF_RFC
  } state_t;

  localparam int DEF_T_RESET  = 40000;
  localparam int DEF_T_CKE    = 100000;
  localparam int DEF_T_XPR    = 72;
  localparam int DEF_T_MRD    = 4;
  localparam int DEF_T_MOD    = 12;
  localparam int DEF_T_ZQINIT = 512;
  localparam int DEF_T_RP     = 6;
  localparam int DEF_T_RFC    = 64;
  localparam int DEF_T_REFI   = 1560;

  localparam logic [13:0] DEF_MR0 = 14'h0520;
  localparam logic [13:0] DEF_MR1 = 14'h0004;
  localparam logic [13:0] DEF_MR2 = 14'h0000;
  localparam logic [13:0] DEF_MR3 = 14'h0000;

  function automatic int max_timing(input int t_reset, input int t_cke,
                                    input int t_xpr, input int t_mrd,
                                    input int t_mod, input int t_zqinit,
                                    input int t_rp, input int t_rfc,
                                    input int t_refi);
    int m;
    m = t_reset;
    if (t_cke    > m) m = t_cke;
    if (t_xpr    > m) m = t_xpr;
    if (t_mrd    > m) m = t_mrd;
    if (t_mod    > m) m = t_mod;
    if (t_zqinit > m) m = t_zqinit;
    if (t_rp     > m) m = t_rp;
    if (t_rfc    > m) m = t_rfc;
    if (t_refi   > m) m = t_refi;
    return m;
  endfunction

endpackage

// File: rtl/sddr_timer.sv
// ---------------------------------------------------------------------------
// sddr_timer
// Loadable down-counter that stops at zero.
//   clk, rst_n  - clock, asynchronous active-low reset (count clears to 0)
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - value to load
//   zero        - count is zero
// ---------------------------------------------------------------------------
module sddr_timer #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sddr_init_sequencer.sv
// ---------------------------------------------------------------------------
// sddr_init_sequencer
// DDR3 power-up sequence (RESET#, CKE, MRS2/3/1/0, ZQCL) followed by periodic
// auto-refresh with a request/grant handshake toward the future scheduler.
// Everything runs on the DDR clock; all outputs are registered.
//
// Build option: define SDDR_AUTO_REFRESH_EN to include the refresh interval
// counter, postponed-refresh counter and handshake. Without it ref_req_o is
// tied 0, ref_gnt_i is ignored and IDLE is terminal.
//
// Ports:
//   in_ddr_clock_i    DDR controller clock
//   in_ddr_reset_n_i  asynchronous active-low reset
//   ddr_reset_n_o     DDR3 RESET# toward the PHY
//   ctl_cke_o/odt_o   CKE / ODT (ODT is always 0)
//   ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o, ctl_ba_o, ctl_addr_o  command bus
//   init_done_o       init complete (sticky until reset)
//   ref_req_o         refresh wanted, scheduler must release the bus
//   ref_gnt_i         scheduler has released the bus
//   busy_o            sequencer owns the command bus
// ---------------------------------------------------------------------------
module sddr_init_sequencer
  import sddr_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int ADDR_BITS = 14,
  parameter int T_RESET   = DEF_T_RESET,
  parameter int T_CKE     = DEF_T_CKE,
  parameter int T_XPR     = DEF_T_XPR,
  parameter int T_MRD     = DEF_T_MRD,
  parameter int T_MOD     = DEF_T_MOD,
  parameter int T_ZQINIT  = DEF_T_ZQINIT,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RFC     = DEF_T_RFC,
  parameter int T_REFI    = DEF_T_REFI,
  parameter logic [ADDR_BITS-1:0] MR0 = ADDR_BITS'(DEF_MR0),
  parameter logic [ADDR_BITS-1:0] MR1 = ADDR_BITS'(DEF_MR1),
  parameter logic [ADDR_BITS-1:0] MR2 = ADDR_BITS'(DEF_MR2),
  parameter logic [ADDR_BITS-1:0] MR3 = ADDR_BITS'(DEF_MR3)
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_ddr_reset_n_i,
  output logic                 ddr_reset_n_o,
  output logic                 ctl_cke_o,
  output logic                 ctl_odt_o,
  output logic                 ctl_ras_n_o,
  output logic                 ctl_cas_n_o,
  output logic                 ctl_we_n_o,
  output logic [BANK_BITS-1:0] ctl_ba_o,
  output logic [ADDR_BITS-1:0] ctl_addr_o,
  output logic                 init_done_o,
  output logic                 ref_req_o,
  input  logic                 ref_gnt_i,
  output logic                 busy_o
);

  localparam int TW = $clog2(max_timing(T_RESET, T_CKE, T_XPR, T_MRD, T_MOD,
                                        T_ZQINIT, T_RP, T_RFC, T_REFI)) + 1;
  localparam logic [ADDR_BITS-1:0] A10 = ADDR_BITS'(1) << 10;

  state_t               state_reg, state_next;
  logic                 armed_reg, armed_next;
  logic                 ddr_reset_n_reg, ddr_reset_n_next;
  logic                 cke_reg, cke_next;
  cmd_t                 cmd_reg, cmd_next;
  logic [BANK_BITS-1:0] ba_reg, ba_next;
  logic [ADDR_BITS-1:0] addr_reg, addr_next;
  logic                 init_done_reg, init_done_next;
  logic                 busy_reg, busy_next;

  logic                 tmr_load;
  logic [TW-1:0]        tmr_value;
  logic                 tmr_zero;

  // Waits load N-1 in the cycle the command is registered; the transition
  // fires the cycle after the count hits zero, so commands are N apart.
  sddr_timer #(.WIDTH(TW)) u_wait_timer (
    .clk        (in_ddr_clock_i),
    .rst_n      (in_ddr_reset_n_i),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

`ifdef SDDR_AUTO_REFRESH_EN
  logic       ref_req_reg, ref_req_next;
  logic [1:0] post_reg, post_next;
  logic       refi_zero, refi_load, refi_tick;
  logic       enter_idle, ref_consume, ref_done;

  assign enter_idle  = (state_reg == ST_ZQCL) && tmr_zero;
  assign refi_tick   = init_done_reg && refi_zero;
  assign refi_load   = enter_idle || refi_tick;
  assign ref_consume = (state_reg == ST_IDLE) && ref_req_reg && ref_gnt_i;
  assign ref_done    = (state_reg == ST_REF_RFC) && tmr_zero;

  // Free-running interval: reloads on its own expiry regardless of whether
  // the previous refresh has been granted yet.
  sddr_timer #(.WIDTH(TW)) u_refi_timer (
    .clk        (in_ddr_clock_i),
    .rst_n      (in_ddr_reset_n_i),
    .load       (refi_load),
    .load_value (TW'(T_REFI - 1)),
    .zero       (refi_zero)
  );

  // Refreshes owed = ref_req + post. The request is kept up across a PRE
  // while postponed ones remain; post is retired when a refresh completes.
  always_comb begin
    ref_req_next = ref_req_reg;
    post_next    = post_reg;
    if (ref_consume && (post_reg == 2'd0)) ref_req_next = 1'b0;
    if (ref_done && (post_reg != 2'd0))    post_next    = post_reg - 2'd1;
    if (refi_tick) begin
      if (ref_req_next) begin
        if (post_next != 2'd3) post_next = post_next + 2'd1;
      end else begin
        ref_req_next = 1'b1;
      end
    end
  end

  always_ff @(posedge in_ddr_clock_i or negedge in_ddr_reset_n_i) begin
    if (!in_ddr_reset_n_i) begin
      ref_req_reg <= 1'b0;
      post_reg    <= 2'd0;
    end else begin
      ref_req_reg <= ref_req_next;
      post_reg    <= post_next;
    end
  end

  assign ref_req_o = ref_req_reg;
`else
  logic unused_ref_gnt;
  assign unused_ref_gnt = ref_gnt_i;
  assign ref_req_o      = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    armed_next       = armed_reg;
    ddr_reset_n_next = ddr_reset_n_reg;
    cke_next         = cke_reg;
    cmd_next         = CMD_NOP;
    ba_next          = '0;
    addr_next        = '0;
    init_done_next   = init_done_reg;
    busy_next        = busy_reg;
    tmr_load         = 1'b0;
    tmr_value        = '0;

    case (state_reg)
      ST_RST_HOLD: begin
        // The counter is 0 out of reset, so the first cycle arms the hold.
        if (!armed_reg) begin
          armed_next = 1'b1;
          tmr_load   = 1'b1;
          tmr_value  = TW'(T_RESET - 1);
        end else if (tmr_zero) begin
          ddr_reset_n_next = 1'b1;
          tmr_load         = 1'b1;
          tmr_value        = TW'(T_CKE - 1);
          state_next       = ST_CKE_WAIT;
        end
      end
      ST_CKE_WAIT: if (tmr_zero) begin
        cke_next   = 1'b1;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_XPR - 1);
        state_next = ST_XPR_WAIT;
      end
      ST_XPR_WAIT: if (tmr_zero) begin
        cmd_next   = CMD_MRS;
        ba_next    = BANK_BITS'(2);
        addr_next  = MR2;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_MRD - 1);
        state_next = ST_MRS2;
      end
      ST_MRS2: if (tmr_zero) begin
        cmd_next   = CMD_MRS;
        ba_next    = BANK_BITS'(3);
        addr_next  = MR3;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_MRD - 1);
        state_next = ST_MRS3;
      end
      ST_MRS3: if (tmr_zero) begin
        cmd_next   = CMD_MRS;
        ba_next    = BANK_BITS'(1);
        addr_next  = MR1;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_MRD - 1);
        state_next = ST_MRS1;
      end
      ST_MRS1: if (tmr_zero) begin
        cmd_next   = CMD_MRS;
        ba_next    = BANK_BITS'(0);
        addr_next  = MR0;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_MOD - 1);
        state_next = ST_MRS0;
      end
      ST_MRS0: if (tmr_zero) begin
        cmd_next   = CMD_ZQCL;
        addr_next  = A10;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_ZQINIT - 1);
        state_next = ST_ZQCL;
      end
      ST_ZQCL: if (tmr_zero) begin
        init_done_next = 1'b1;
        busy_next      = 1'b0;
        state_next     = ST_IDLE;
      end
      ST_IDLE: begin
`ifdef SDDR_AUTO_REFRESH_EN
        if (ref_consume) begin
          cmd_next   = CMD_PRE;
          addr_next  = A10;
          busy_next  = 1'b1;
          tmr_load   = 1'b1;
          tmr_value  = TW'(T_RP - 1);
          state_next = ST_REF_PRE;
        end
`endif
      end
`ifdef SDDR_AUTO_REFRESH_EN
      ST_REF_PRE: if (tmr_zero) begin
        cmd_next   = CMD_REF;
        tmr_load   = 1'b1;
        tmr_value  = TW'(T_RFC - 1);
        state_next = ST_REF_RFC;
      end
      ST_REF_RFC: if (tmr_zero) begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
`endif
      default: begin
        state_next = ST_RST_HOLD;
        armed_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_ddr_clock_i or negedge in_ddr_reset_n_i) begin
    if (!in_ddr_reset_n_i) begin
      state_reg       <= ST_RST_HOLD;
      armed_reg       <= 1'b0;
      ddr_reset_n_reg <= 1'b0;
      cke_reg         <= 1'b0;
      cmd_reg         <= CMD_NOP;
      ba_reg          <= '0;
      addr_reg        <= '0;
      init_done_reg   <= 1'b0;
      busy_reg        <= 1'b1;
    end else begin
      state_reg       <= state_next;
      armed_reg       <= armed_next;
      ddr_reset_n_reg <= ddr_reset_n_next;
      cke_reg         <= cke_next;
      cmd_reg         <= cmd_next;
      ba_reg          <= ba_next;
      addr_reg        <= addr_next;
      init_done_reg   <= init_done_next;
      busy_reg        <= busy_next;
    end
  end

  assign ddr_reset_n_o = ddr_reset_n_reg;
  assign ctl_cke_o     = cke_reg;
  assign ctl_odt_o     = 1'b0;
  assign {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} = cmd_reg;
  assign ctl_ba_o      = ba_reg;
  assign ctl_addr_o    = addr_reg;
  assign init_done_o   = init_done_reg;
  assign busy_o        = busy_reg;

endmodule

// File: tb/tb_sddr_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sddr_init_sequencer
// Directed bench for sddr_init_sequencer with shortened timings. Cycle numbers
// count DDR clock edges after reset release; outputs are sampled on the
// falling clock edge. With SDDR_AUTO_REFRESH_EN defined the refresh
// handshake is exercised, otherwise the idle bus is watched for 1000 cycles.
// ---------------------------------------------------------------------------
module tb_sddr_init_sequencer;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ZQ  = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  // Expected init commands: MRS2, MRS3, MRS1, MRS0 (2 apart), ZQCL 3 later.
  localparam int EXP_CMD  [5] = '{0, 0, 0, 0, 6};
  localparam int EXP_BA   [5] = '{2, 3, 1, 0, 0};
  localparam int EXP_ADDR [5] = '{'h0008, 'h0002, 'h0004, 'h0520, 'h0400};
  localparam int EXP_AT   [5] = '{14, 16, 18, 20, 23};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ref_gnt;
  logic        ddr_reset_n_o, ctl_cke_o, ctl_odt_o;
  logic        ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o;
  logic [2:0]  ctl_ba_o;
  logic [13:0] ctl_addr_o;
  logic        init_done_o, ref_req_o, busy_o;
  logic [2:0]  cmd_obs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel   = 0;
  int viol  = 0;

  logic [2:0]  c_got, b_got;
  logic [13:0] a_got;
  int          at_got;

  sddr_init_sequencer #(
    .T_RESET (4), .T_CKE (6), .T_XPR (3), .T_MRD (2), .T_MOD (3),
    .T_ZQINIT(5), .T_RP (6), .T_RFC (4), .T_REFI (20),
    .MR2     (14'h0008), .MR3 (14'h0002)
  ) dut (
    .in_ddr_clock_i  (clk),
    .in_ddr_reset_n_i(rst_n),
    .ddr_reset_n_o   (ddr_reset_n_o),
    .ctl_cke_o       (ctl_cke_o),
    .ctl_odt_o       (ctl_odt_o),
    .ctl_ras_n_o     (ctl_ras_n_o),
    .ctl_cas_n_o     (ctl_cas_n_o),
    .ctl_we_n_o      (ctl_we_n_o),
    .ctl_ba_o        (ctl_ba_o),
    .ctl_addr_o      (ctl_addr_o),
    .init_done_o     (init_done_o),
    .ref_req_o       (ref_req_o),
    .ref_gnt_i       (ref_gnt),
    .busy_o          (busy_o)
  );

  assign cmd_obs = {ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus rules after init: CKE high, ODT low, only PRE/REF, never two
  // consecutive non-NOP cycles.
  logic prev_active = 1'b0;
  always @(negedge clk) begin
    if (rst_n && init_done_o) begin
      if (!ctl_cke_o || ctl_odt_o) viol++;
      if (cmd_obs != C_NOP && cmd_obs != C_PRE && cmd_obs != C_REF) viol++;
      if (prev_active && cmd_obs != C_NOP) viol++;
      prev_active = (cmd_obs != C_NOP);
    end else begin
      prev_active = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_ddr_reset_n"}, ddr_reset_n_o, 0);
    check_eq({pfx, "_cke"},         ctl_cke_o,     0);
    check_eq({pfx, "_odt"},         ctl_odt_o,     0);
    check_eq({pfx, "_cmd"},         cmd_obs,       C_NOP);
    check_eq({pfx, "_ba"},          ctl_ba_o,      0);
    check_eq({pfx, "_addr"},        ctl_addr_o,    0);
    check_eq({pfx, "_init_done"},   init_done_o,   0);
    check_eq({pfx, "_ref_req"},     ref_req_o,     0);
    check_eq({pfx, "_busy"},        busy_o,        1);
  endtask

  // Waits (bounded) for the next non-NOP command; call on a falling edge.
  task automatic wait_cmd(input string tag, output logic [2:0] c,
                          output logic [2:0] b, output logic [13:0] a,
                          output int at);
    bit found;
    found = 1'b0;
    c = C_NOP; b = '0; a = '0; at = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (cmd_obs != C_NOP) begin
        found = 1'b1;
        c = cmd_obs; b = ctl_ba_o; a = ctl_addr_o; at = cyc - rel;
      end
    end
    check_eq({tag, "_found"}, found, 1);
  endtask

  task automatic goto_cycle(input int k);
    while (cyc - rel < k) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  task automatic run_init(input string pfx);
    int t_rst, t_cke, t_done;
    t_rst = -1; t_cke = -1; t_done = -1;
    release_reset();
    for (int i = 0; i < 40 && t_cke < 0; i++) begin
      @(negedge clk);
      if (ddr_reset_n_o && t_rst < 0) t_rst = cyc - rel;
      if (ctl_cke_o && t_cke < 0)     t_cke = cyc - rel;
    end
    check_eq({pfx, "_reset_rise"}, t_rst, 5);
    check_eq({pfx, "_cke_rise"},   t_cke, 11);
    for (int i = 0; i < 5; i++) begin
      wait_cmd($sformatf("%s_cmd%0d", pfx, i), c_got, b_got, a_got, at_got);
      check_eq($sformatf("%s_cmd%0d_code", pfx, i), c_got, EXP_CMD[i]);
      check_eq($sformatf("%s_cmd%0d_ba", pfx, i),   b_got, EXP_BA[i]);
      check_eq($sformatf("%s_cmd%0d_addr", pfx, i), a_got, EXP_ADDR[i]);
      check_eq($sformatf("%s_cmd%0d_at", pfx, i),   at_got, EXP_AT[i]);
    end
    for (int i = 0; i < 40 && t_done < 0; i++) begin
      @(negedge clk);
      if (init_done_o) t_done = cyc - rel;
    end
    check_eq({pfx, "_done_at"}, t_done, 28);
    check_eq({pfx, "_busy_idle"}, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cmd, n_req;
    rst_n   = 1'b0;
    ref_gnt = 1'b1;  // grant with no pending request must be ignored
    repeat (3) @(negedge clk);
    check_reset("por");

    // Reset while waiting after MRS1: outputs return at once, then restart.
    release_reset();
    for (int i = 0; i < 3; i++)
      wait_cmd($sformatf("pre_mrs%0d", i), c_got, b_got, a_got, at_got);
    check_eq("pre_mrs1_ba", b_got, 1);
    check_eq("pre_mrs1_at", at_got, 18);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_async");
    @(negedge clk);
    check_reset("mid_held");

    run_init("init1");

`ifdef SDDR_AUTO_REFRESH_EN
    // Grant tied high: request at 48, PRE 49, REF 55, bus released at 59,
    // and the same pattern 20 cycles later.
    begin
      int t_req;
      t_req = -1;
      for (int i = 0; i < 40 && t_req < 0; i++) begin
        @(negedge clk);
        if (ref_req_o) t_req = cyc - rel;
      end
      check_eq("r1_req_at", t_req, 48);
    end
    wait_cmd("r1_pre", c_got, b_got, a_got, at_got);
    check_eq("r1_pre_code", c_got, C_PRE);
    check_eq("r1_pre_a10",  a_got, 14'h0400);
    check_eq("r1_pre_at",   at_got, 49);
    check_eq("r1_pre_req",  ref_req_o, 0);
    check_eq("r1_pre_busy", busy_o, 1);
    wait_cmd("r1_ref", c_got, b_got, a_got, at_got);
    check_eq("r1_ref_code", c_got, C_REF);
    check_eq("r1_ref_at",   at_got, 55);
    goto_cycle(58);
    check_eq("r1_busy_rfc", busy_o, 1);
    goto_cycle(59);
    check_eq("r1_busy_end", busy_o, 0);
    wait_cmd("r2_pre", c_got, b_got, a_got, at_got);
    check_eq("r2_pre_code", c_got, C_PRE);
    check_eq("r2_pre_at",   at_got, 69);
    wait_cmd("r2_ref", c_got, b_got, a_got, at_got);
    check_eq("r2_ref_code", c_got, C_REF);
    check_eq("r2_ref_at",   at_got, 75);

    // Grant withheld over two interval expiries (48, 68): two refreshes owed.
    rst_n   = 1'b0;
    ref_gnt = 1'b0;
    @(negedge clk);
    run_init("init2");
    goto_cycle(67);
    check_eq("p_req_held", ref_req_o, 1);
    check_eq("p_busy_idle", busy_o, 0);
    goto_cycle(68);
    ref_gnt = 1'b1;
    wait_cmd("p1_pre", c_got, b_got, a_got, at_got);
    check_eq("p1_pre_code", c_got, C_PRE);
    check_eq("p1_pre_at",   at_got, 69);
    check_eq("p1_req_kept", ref_req_o, 1);
    wait_cmd("p1_ref", c_got, b_got, a_got, at_got);
    check_eq("p1_ref_code", c_got, C_REF);
    check_eq("p1_ref_at",   at_got, 75);
    goto_cycle(79);
    check_eq("p1_busy_end", busy_o, 0);
    wait_cmd("p2_pre", c_got, b_got, a_got, at_got);
    check_eq("p2_pre_code", c_got, C_PRE);
    check_eq("p2_pre_at",   at_got, 80);
    check_eq("p2_req_drop", ref_req_o, 0);
    wait_cmd("p2_ref", c_got, b_got, a_got, at_got);
    check_eq("p2_ref_code", c_got, C_REF);
    check_eq("p2_ref_at",   at_got, 86);
    goto_cycle(87);
    check_eq("p2_req_low", ref_req_o, 0);
`else
    // No refresh logic: bus stays NOP and no request even with grant high.
    n_cmd = 0;
    n_req = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_obs != C_NOP) n_cmd++;
      if (ref_req_o)        n_req++;
    end
    check_eq("idle_non_nop", n_cmd, 0);
    check_eq("idle_ref_req", n_req, 0);
    check_eq("idle_done",    init_done_o, 1);
    check_eq("idle_busy",    busy_o, 0);
`endif

    check_eq("bus_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
